// File: rtl/nco_tone_sequencer.sv
// Table-driven sequencer that steps the NCO phase increment through (freq, dur) pairs.
// Optional macro NCO_SEQ_RAMP_EN: freq_word slews by +/-1 per PLAY cycle instead of jumping.
module nco_tone_sequencer #(
    parameter  int DEPTH = 8,
    parameter  int FW    = 8,
    parameter  int DW    = 8,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_addr,
    input  logic [FW-1:0] wr_freq,
    input  logic [DW-1:0] wr_dur,
    input  logic          start,
    input  logic          stop,
    input  logic          loop_en,
    output logic [FW-1:0] freq_word,
    output logic          busy,
    output logic [IW-1:0] step_idx,
    output logic          step_done,
    output logic          seq_done
);

    typedef enum logic [1:0] {IDLE, FETCH, PLAY, DONE} state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    state_t        state, state_n;
    logic [IW-1:0] idx_n;
    logic [DW-1:0] cnt, cnt_n;
    logic [FW-1:0] freq_n;
    logic          end_tbl;

    logic [FW-1:0] tbl_freq [DEPTH];
    logic [DW-1:0] tbl_dur  [DEPTH];
    logic [FW-1:0] rd_freq;
    logic [DW-1:0] rd_dur;

`ifdef NCO_SEQ_RAMP_EN
    logic [FW-1:0] target, target_n;

    function automatic logic [FW-1:0] slew(input logic [FW-1:0] cur, input logic [FW-1:0] tgt);
        if ($signed(cur) < $signed(tgt))
            return cur + FW'(1);
        else if ($signed(cur) > $signed(tgt))
            return cur - FW'(1);
        return cur;
    endfunction
`endif

    // The table has no reset so a programmed sequence survives rst_n.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tbl_freq[wr_addr] <= wr_freq;
            tbl_dur[wr_addr]  <= wr_dur;
        end
    end

    assign rd_freq = tbl_freq[step_idx];
    assign rd_dur  = tbl_dur[step_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            step_idx  <= '0;
            cnt       <= '0;
            freq_word <= '0;
`ifdef NCO_SEQ_RAMP_EN
            target    <= '0;
`endif
        end else begin
            state     <= state_n;
            step_idx  <= idx_n;
            cnt       <= cnt_n;
            freq_word <= freq_n;
`ifdef NCO_SEQ_RAMP_EN
            target    <= target_n;
`endif
        end
    end

    always_comb begin
        state_n  = state;
        idx_n    = step_idx;
        cnt_n    = cnt;
        freq_n   = freq_word;
        end_tbl  = 1'b0;
`ifdef NCO_SEQ_RAMP_EN
        target_n = target;
`endif
        case (state)
            IDLE: begin
                freq_n = '0;
                if (start) begin
                    state_n = FETCH;
                    idx_n   = '0;
                end
            end
            FETCH: begin
                if (rd_dur != '0) begin
                    state_n  = PLAY;
                    cnt_n    = rd_dur;
`ifdef NCO_SEQ_RAMP_EN
                    freq_n   = slew(freq_word, rd_freq);
                    target_n = rd_freq;
`else
                    freq_n   = rd_freq;
`endif
                end else begin
                    end_tbl = 1'b1;
                end
            end
            PLAY: begin
                cnt_n = cnt - 1'b1;
                if (cnt == DW'(1)) begin
                    if (step_idx == LAST_IDX) begin
                        end_tbl = 1'b1;
                    end else begin
                        idx_n   = step_idx + 1'b1;
                        state_n = FETCH;
                    end
                end else begin
`ifdef NCO_SEQ_RAMP_EN
                    freq_n = slew(freq_word, target);
`endif
                end
            end
            DONE: begin
                state_n = IDLE;
                freq_n  = '0;
            end
            default: state_n = IDLE;
        endcase

        // Looping from entry 0 back to entry 0 would spin forever, so it always finishes.
        if (end_tbl) begin
            if (loop_en && step_idx != '0) begin
                idx_n   = '0;
                state_n = FETCH;
            end else begin
                state_n = DONE;
                freq_n  = '0;
            end
        end

        if (stop) begin
            state_n = IDLE;
            idx_n   = '0;
            freq_n  = '0;
        end
    end

    assign busy      = (state == FETCH) || (state == PLAY);
    assign step_done = (state == PLAY) && (cnt == DW'(1));
    assign seq_done  = (state == DONE);

endmodule

// File: tb/tb_nco_tone_sequencer.sv
// Directed testbench for nco_tone_sequencer; the ramp scenario runs when NCO_SEQ_RAMP_EN is defined.
module tb_nco_tone_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_freq;
    logic [7:0] wr_dur;
    logic       start;
    logic       stop;
    logic       loop_en;
    logic [7:0] freq_word;
    logic       busy;
    logic [2:0] step_idx;
    logic       step_done;
    logic       seq_done;

    int n_checks = 0;
    int n_fail   = 0;

    nco_tone_sequencer #(.DEPTH(8), .FW(8), .DW(8)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_freq(wr_freq), .wr_dur(wr_dur), .start(start), .stop(stop),
        .loop_en(loop_en), .freq_word(freq_word), .busy(busy),
        .step_idx(step_idx), .step_done(step_done), .seq_done(seq_done)
    );

    always #5 clk = ~clk;

    task automatic write_entry(input logic [2:0] a, input logic [7:0] f, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_freq = f; wr_dur = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_freq = '0; wr_dur = '0;
        start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        #2;
        n_checks++;
        if ({freq_word, step_idx, busy, step_done, seq_done} !== 14'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_async: got freq=%h idx=%0d flags=%b%b%b, expected all zero",
                     freq_word, step_idx, busy, step_done, seq_done);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({freq_word, step_idx, busy, step_done, seq_done} !== 14'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_release: got freq=%h idx=%0d flags=%b%b%b, expected all zero",
                     freq_word, step_idx, busy, step_done, seq_done);
        end
    endtask

`ifdef NCO_SEQ_RAMP_EN
    task automatic test_ramp();
        logic [7:0] exp_f [19];
        logic [2:0] exp_flags;
        exp_f = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 8'h04, 8'h04, 8'h03, 8'h02,
                  8'h01, 8'h00, 8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'h00, 8'h00};
        write_entry(3'd0, 8'h04, 8'd6);
        write_entry(3'd1, 8'hFE, 8'd8);
        write_entry(3'd2, 8'h00, 8'd0);
        loop_en = 1'b0;
        pulse_start();
        for (int k = 0; k < 19; k++) begin
            @(negedge clk);
            exp_flags = {k <= 16, (k == 6) || (k == 15), k == 17};
            n_checks++;
            if ({freq_word, busy, step_done, seq_done} !== {exp_f[k], exp_flags}) begin
                n_fail++;
                $display("[TB] FAIL ramp cycle %0d: got freq=%h flags=%b%b%b, expected freq=%h flags=%b",
                         k, freq_word, busy, step_done, seq_done, exp_f[k], exp_flags);
            end
        end
    endtask
`else
    task automatic test_single_tone();
        logic [10:0] exp_v [7];
        exp_v = '{{8'h00, 3'b100}, {8'h10, 3'b100}, {8'h10, 3'b100}, {8'h10, 3'b110},
                  {8'h10, 3'b100}, {8'h00, 3'b001}, {8'h00, 3'b000}};
        write_entry(3'd0, 8'h10, 8'd3);
        write_entry(3'd1, 8'h55, 8'd0);
        loop_en = 1'b0;
        pulse_start();
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            n_checks++;
            if ({freq_word, busy, step_done, seq_done} !== exp_v[k]) begin
                n_fail++;
                $display("[TB] FAIL single_tone cycle %0d: got freq=%h flags=%b%b%b, expected freq=%h flags=%b",
                         k, freq_word, busy, step_done, seq_done, exp_v[k][10:3], exp_v[k][2:0]);
            end
        end
    endtask

    // Plays the eight (i+1, 2) entries already in the table and checks the whole trace.
    task automatic run_full_table(input string name);
        int         busy_cnt = 0;
        int         sd_cnt   = 0;
        int         i;
        int         ph;
        logic [7:0] exp_f;
        logic [2:0] exp_flags;
        pulse_start();
        for (int k = 0; k < 26; k++) begin
            @(negedge clk);
            i  = k / 3;
            ph = k % 3;
            if (k < 24) begin
                exp_f     = (ph == 0) ? 8'(i) : 8'(i + 1);
                exp_flags = {1'b1, ph == 2, 1'b0};
            end else begin
                exp_f     = 8'h00;
                exp_flags = (k == 24) ? 3'b001 : 3'b000;
            end
            n_checks++;
            if ({freq_word, busy, step_done, seq_done} !== {exp_f, exp_flags}) begin
                n_fail++;
                $display("[TB] FAIL %s cycle %0d: got freq=%h flags=%b%b%b, expected freq=%h flags=%b",
                         name, k, freq_word, busy, step_done, seq_done, exp_f, exp_flags);
            end
            if (k < 24) begin
                n_checks++;
                if (step_idx !== 3'(i)) begin
                    n_fail++;
                    $display("[TB] FAIL %s step_idx cycle %0d: got %0d, expected %0d", name, k, step_idx, i);
                end
            end
            busy_cnt += int'(busy);
            sd_cnt   += int'(step_done);
        end
        n_checks++;
        if (busy_cnt != 24) begin
            n_fail++;
            $display("[TB] FAIL %s busy_count: got %0d, expected 24", name, busy_cnt);
        end
        n_checks++;
        if (sd_cnt != 8) begin
            n_fail++;
            $display("[TB] FAIL %s step_done_count: got %0d, expected 8", name, sd_cnt);
        end
    endtask

    task automatic test_full_table();
        for (int i = 0; i < 8; i++)
            write_entry(3'(i), 8'(i + 1), 8'd2);
        loop_en = 1'b0;
        run_full_table("full_table");
    endtask

    task automatic test_reset_mid_play();
        pulse_start();
        repeat (5) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({freq_word, step_idx, busy, step_done, seq_done} !== 14'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_play: got freq=%h idx=%0d flags=%b%b%b, expected all zero",
                     freq_word, step_idx, busy, step_done, seq_done);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_full_table("replay_after_reset");
    endtask

    task automatic test_loop_stop();
        int         p;
        logic [7:0] exp_f;
        logic [2:0] exp_flags;
        logic [2:0] exp_idx;
        write_entry(3'd0, 8'h7F, 8'd1);
        write_entry(3'd1, 8'h80, 8'd1);
        write_entry(3'd2, 8'h00, 8'd0);
        loop_en = 1'b1;
        pulse_start();
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (k == 0) begin
                exp_f = 8'h00; exp_flags = 3'b100; exp_idx = 3'd0;
            end else begin
                p         = (k - 1) % 5;
                exp_f     = (p < 2) ? 8'h7F : 8'h80;
                exp_flags = {1'b1, (p == 0) || (p == 2), 1'b0};
                exp_idx   = (p == 0 || p == 4) ? 3'd0 : ((p == 3) ? 3'd2 : 3'd1);
            end
            n_checks++;
            if ({freq_word, step_idx, busy, step_done, seq_done} !== {exp_f, exp_idx, exp_flags}) begin
                n_fail++;
                $display("[TB] FAIL loop cycle %0d: got freq=%h idx=%0d flags=%b%b%b, expected freq=%h idx=%0d flags=%b",
                         k, freq_word, step_idx, busy, step_done, seq_done, exp_f, exp_idx, exp_flags);
            end
        end
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++;
            if ({freq_word, busy, step_done, seq_done} !== 11'd0) begin
                n_fail++;
                $display("[TB] FAIL stop_on_step_done cycle %0d: got freq=%h flags=%b%b%b, expected idle zeros",
                         k, freq_word, busy, step_done, seq_done);
            end
        end
        start = 1'b1; stop = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({freq_word, busy, step_done, seq_done} !== 11'd0) begin
            n_fail++;
            $display("[TB] FAIL stop_beats_start: got freq=%h flags=%b%b%b, expected idle zeros",
                     freq_word, busy, step_done, seq_done);
        end
        write_entry(3'd0, 8'h55, 8'd0);
        pulse_start();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            exp_flags = (k == 0) ? 3'b100 : ((k == 1) ? 3'b001 : 3'b000);
            n_checks++;
            if ({freq_word, busy, step_done, seq_done} !== {8'h00, exp_flags}) begin
                n_fail++;
                $display("[TB] FAIL marker_at_zero cycle %0d: got freq=%h flags=%b%b%b, expected freq=00 flags=%b",
                         k, freq_word, busy, step_done, seq_done, exp_flags);
            end
        end
        loop_en = 1'b0;
    endtask

    task automatic test_live_write();
        logic [10:0] exp_v [15];
        exp_v = '{{8'h00, 3'b100}, {8'h11, 3'b100}, {8'h11, 3'b110}, {8'h11, 3'b100},
                  {8'h22, 3'b100}, {8'h22, 3'b100}, {8'h22, 3'b100}, {8'h22, 3'b110},
                  {8'h22, 3'b100}, {8'h44, 3'b100}, {8'h44, 3'b110}, {8'h44, 3'b100},
                  {8'h00, 3'b001}, {8'h00, 3'b000}, {8'h00, 3'b000}};
        write_entry(3'd0, 8'h11, 8'd2);
        write_entry(3'd1, 8'h22, 8'd4);
        write_entry(3'd2, 8'h33, 8'd2);
        write_entry(3'd3, 8'h00, 8'd0);
        loop_en = 1'b0;
        start   = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            n_checks++;
            if ({freq_word, busy, step_done, seq_done} !== exp_v[k]) begin
                n_fail++;
                $display("[TB] FAIL live_write cycle %0d: got freq=%h flags=%b%b%b, expected freq=%h flags=%b",
                         k, freq_word, busy, step_done, seq_done, exp_v[k][10:3], exp_v[k][2:0]);
            end
            if (k == 4) begin
                wr_en = 1'b1; wr_addr = 3'd2; wr_freq = 8'h44; wr_dur = 8'd2;
            end
            if (k == 5)
                wr_en = 1'b0;
            if (k == 9)
                start = 1'b0;
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef NCO_SEQ_RAMP_EN
        test_ramp();
`else
        test_single_tone();
        test_full_table();
        test_reset_mid_play();
        test_loop_stop();
        test_live_write();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
